// File: rtl/c1_bus_arbiter_pkg.sv
// Shared definitions for the C1 cache bus arbiter: bus geometry, C1 command
// codes, the request payload and the transaction state type.
package c1_bus_arbiter_pkg;

    localparam int unsigned CTR1_BUS_SIZE     = 4;
    localparam int unsigned CACHE_ADDR_SIZE   = 16;
    localparam int unsigned CACHE_OFFSET_SIZE = 4;
    localparam int unsigned ADDR1_BUS_SIZE    = CACHE_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int unsigned DATA_BUS_SIZE     = 16;
    localparam int unsigned WORD_SIZE         = 32;

    typedef logic [CTR1_BUS_SIZE-1:0] c1_cmd_t;

    localparam c1_cmd_t C1_NOP             = 4'h0;
    localparam c1_cmd_t C1_READ8           = 4'h1;
    localparam c1_cmd_t C1_READ16          = 4'h2;
    localparam c1_cmd_t C1_READ32          = 4'h3;
    localparam c1_cmd_t C1_INVALIDATE_LINE = 4'h4;
    localparam c1_cmd_t C1_WRITE8          = 4'h5;
    localparam c1_cmd_t C1_WRITE16         = 4'h6;
    localparam c1_cmd_t C1_WRITE32         = 4'h7;
    localparam c1_cmd_t C1_RESPONSE        = 4'h8;

    typedef struct packed {
        c1_cmd_t                    cmd;
        logic [CACHE_ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0]       wdata;
    } c1_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_CMD2,
        ST_WAIT_RESP,
        ST_READ2,
        ST_DONE
    } c1_state_t;

    function automatic logic is_write(input c1_cmd_t cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    // D1 word in the first command cycle; the first byte of a word rides on D1[7:0].
    function automatic logic [DATA_BUS_SIZE-1:0] d1_first_word(input c1_cmd_t cmd,
                                                               input logic [WORD_SIZE-1:0] wdata);
        logic [DATA_BUS_SIZE-1:0] word;
        word = '0;
        case (cmd)
            C1_WRITE8:  word = {8'h00, wdata[7:0]};
            C1_WRITE16: word = {wdata[7:0], wdata[15:8]};
            C1_WRITE32: word = {wdata[23:16], wdata[31:24]};
            default:    word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/c1_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the valid requester that did not win last time
// is granted; last_grant only moves when the grant is actually taken.
module c1_bus_arbiter_rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant_c,
    output logic       o_last_grant
);

    logic r_last_grant;

    assign o_grant_c    = (&i_req) ? ~r_last_grant : i_req[1];
    assign o_last_grant = r_last_grant;

    // Reset value 1 makes requester 0 win the first contested round.
    always_ff @(posedge i_clk) begin : last_grant_reg
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant_c;
        end
    end

endmodule

// File: rtl/c1_bus_arbiter.sv
// Two-requester master for the cache CPU-side bus (A1/D1/C1): arbitrates,
// sequences command/address, waits for C1_RESPONSE and returns read data.
module c1_bus_arbiter
    import c1_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       r0_valid,
    input  logic                       r1_valid,
    output logic                       r0_ready,
    output logic                       r1_ready,
    input  logic [CTR1_BUS_SIZE-1:0]   r0_cmd,
    input  logic [CTR1_BUS_SIZE-1:0]   r1_cmd,
    input  logic [CACHE_ADDR_SIZE-1:0] r0_addr,
    input  logic [CACHE_ADDR_SIZE-1:0] r1_addr,
    input  logic [WORD_SIZE-1:0]       r0_wdata,
    input  logic [WORD_SIZE-1:0]       r1_wdata,
    output logic                       r0_resp_valid,
    output logic                       r1_resp_valid,
    output logic                       r0_resp_err,
    output logic                       r1_resp_err,
    output logic [WORD_SIZE-1:0]       r0_rdata,
    output logic [WORD_SIZE-1:0]       r1_rdata,
    inout  wire  [ADDR1_BUS_SIZE-1:0]  A1,
    inout  wire  [DATA_BUS_SIZE-1:0]   D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]   C1
);

    c1_state_t             r_state;
    c1_state_t             w_state_nxt;
    c1_req_t               r_req;
    c1_req_t               w_sel_req;
    logic [WORD_SIZE-1:0]  r_acc;
    logic [WORD_SIZE-1:0]  w_acc_nxt;
    logic [WORD_SIZE-1:0]  r_rdata0;
    logic [WORD_SIZE-1:0]  r_rdata1;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_cnt_hit;
    logic                  w_grant;
    logic                  w_owner;
    logic                  w_hs;
    logic                  w_resp_seen;
    logic                  w_publish;
    logic                  w_pub_sel;
    logic                  w_bus_oe;
    logic                  w_d1_oe;
    logic                  w_done;
    logic [ADDR1_BUS_SIZE-1:0] w_a1;
    logic [DATA_BUS_SIZE-1:0]  w_d1;

    c1_bus_arbiter_rr_arbiter2 u_rr (
        .i_clk        (CLK),
        .i_reset      (RESET),
        .i_req        ({r1_valid, r0_valid}),
        .i_accept     (w_hs),
        .o_grant_c    (w_grant),
        .o_last_grant (w_owner)
    );

    assign w_sel_req   = w_grant ? '{cmd: r1_cmd, addr: r1_addr, wdata: r1_wdata}
                                 : '{cmd: r0_cmd, addr: r0_addr, wdata: r0_wdata};
    assign w_hs        = (r_state == ST_IDLE) && (w_grant ? r1_valid : r0_valid);
    assign w_resp_seen = (C1 == C1_RESPONSE);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_cnt_hit   = (r_state == ST_WAIT_RESP) && !w_resp_seen
                         && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign w_publish   = (w_state_nxt == ST_DONE);
    // The owner register only updates at the handshake edge, so a NOP publishes via the live grant.
    assign w_pub_sel   = (r_state == ST_IDLE) ? w_grant : w_owner;

    always_ff @(posedge CLK) begin : state_reg
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = (w_sel_req.cmd == C1_NOP) ? ST_DONE : ST_CMD1;
                end
            end
            ST_CMD1: w_state_nxt = ST_CMD2;
            ST_CMD2: w_state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (w_resp_seen) begin
                    w_state_nxt = (r_req.cmd == C1_READ32) ? ST_READ2 : ST_DONE;
                end else if (w_cnt_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_READ2: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        w_bus_oe = 1'b0;
        w_d1_oe  = 1'b0;
        w_a1     = '0;
        w_d1     = '0;
        w_done   = 1'b0;
        unique case (r_state)
            ST_CMD1: begin
                w_bus_oe = 1'b1;
                w_d1_oe  = is_write(r_req.cmd);
                w_a1     = r_req.addr[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                w_d1     = d1_first_word(r_req.cmd, r_req.wdata);
            end
            ST_CMD2: begin
                w_bus_oe = 1'b1;
                w_d1_oe  = is_write(r_req.cmd);
                w_a1     = ADDR1_BUS_SIZE'(r_req.addr[CACHE_OFFSET_SIZE-1:0]);
                w_d1     = (r_req.cmd == C1_WRITE32) ? {r_req.wdata[7:0], r_req.wdata[15:8]}
                                                     : d1_first_word(r_req.cmd, r_req.wdata);
            end
            ST_DONE: w_done = 1'b1;
            default: w_done = 1'b0;
        endcase
    end

    // Read assembly: each D1 word carries its first byte on [7:0].
    always_comb begin : capture
        w_acc_nxt = r_acc;
        unique case (r_state)
            ST_IDLE: w_acc_nxt = '0;
            ST_WAIT_RESP: begin
                if (w_resp_seen) begin
                    case (r_req.cmd)
                        C1_READ8:  w_acc_nxt = {24'h0, D1[7:0]};
                        C1_READ16: w_acc_nxt = {16'h0, D1[7:0], D1[15:8]};
                        C1_READ32: w_acc_nxt = {D1[7:0], D1[15:8], 16'h0};
                        default:   w_acc_nxt = r_acc;
                    endcase
                end
            end
            ST_READ2: w_acc_nxt = {r_acc[31:16], D1[7:0], D1[15:8]};
            default:  w_acc_nxt = r_acc;
        endcase
    end

    always_ff @(posedge CLK) begin : datapath
        if (RESET) begin
            r_req    <= '0;
            r_acc    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_hs) begin
                r_req <= w_sel_req;
                r_err <= 1'b0;
                r_cnt <= '0;
            end
            if (r_state == ST_WAIT_RESP) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_cnt_hit) begin
                r_err <= 1'b1;
            end
            r_acc <= w_acc_nxt;
            if (w_publish) begin
                if (w_pub_sel) begin
                    r_rdata1 <= w_acc_nxt;
                end else begin
                    r_rdata0 <= w_acc_nxt;
                end
            end
        end
    end

    assign r0_ready      = w_hs && !w_grant;
    assign r1_ready      = w_hs && w_grant;
    assign r0_resp_valid = w_done && !w_owner;
    assign r1_resp_valid = w_done && w_owner;
    assign r0_resp_err   = w_done && !w_owner && r_err;
    assign r1_resp_err   = w_done && w_owner && r_err;
    assign r0_rdata      = r_rdata0;
    assign r1_rdata      = r_rdata1;

    assign A1 = w_bus_oe ? w_a1 : {ADDR1_BUS_SIZE{1'bz}};
    assign C1 = w_bus_oe ? r_req.cmd : {CTR1_BUS_SIZE{1'bz}};
    assign D1 = w_d1_oe ? w_d1 : {DATA_BUS_SIZE{1'bz}};

endmodule

// File: doc/c1_bus_arbiter.md
Name: c1_bus_arbiter

Overview:
- Two-requester master for the cache CPU-side bus (A1/D1/C1).
- Each requester presents one complete transaction in a single cycle: command, full cache address and 32-bit write data.
- Grants the bus round-robin and sequences the two-cycle command/address phase, bus release, response wait and one- or two-cycle read-data phase. Returns assembled read data per requester.
- Sits between CPU-side agents (core, prefetcher/DMA) and the Cache instance.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT_RESP before the transaction aborts with an error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- r0_valid, r1_valid  in  1 each  request pending.
- r0_ready, r1_ready  out  1 each  request accepted this edge (combinational).
- r0_cmd, r1_cmd  in  CTR1_BUS_SIZE each  one of the C1_* commands.
- r0_addr, r1_addr  in  CACHE_ADDR_SIZE each  byte address, tag|set|offset.
- r0_wdata, r1_wdata  in  32 each  write data, MSB-first byte order.
- r0_resp_valid, r1_resp_valid  out  1 each  one-cycle completion pulse.
- r0_resp_err, r1_resp_err  out  1 each  timeout flag, qualified by resp_valid.
- r0_rdata, r1_rdata  out  32 each  read result, held until that requester's next completion.
- A1  inout  ADDR1_BUS_SIZE  cache address bus.
- D1  inout  DATA_BUS_SIZE (16)  cache data bus.
- C1  inout  CTR1_BUS_SIZE  cache command bus.

Behaviour:
- Reset (synchronous, active-high, takes effect at the edge where RESET=1):
  - A1/D1/C1 driven 'z.
  - All ready, resp_valid and resp_err are 0; all rdata are 0.
  - State IDLE; last_grant=1, so r0 wins first; timeout counter 0.
  - RESET asserted mid-transaction aborts it silently: no resp_valid is issued.
- Arbitration in IDLE:
  - Grant goes to the valid requester that is not last_grant. If only one requester is valid, it gets the grant.
  - ready(grant) = IDLE && valid(grant). The handshake completes at that edge; cmd/addr/wdata are latched and last_grant updated.
- C1_NOP request: accepted, no bus activity. Next cycle resp_valid=1 with rdata=0, then back to IDLE.
- Byte convention on D1: the first byte of each word goes on D1[7:0], the second on D1[15:8]. Bytes are numbered MSB-first from wdata/rdata[31:24].
- States and transitions:
  - IDLE -> CMD1 on handshake.
  - CMD1, 1 cycle:
    - C1=cmd; A1=addr>>CACHE_OFFSET_SIZE.
    - WRITE8: D1[7:0]=wdata[7:0].
    - WRITE16: D1 = wdata[15:8] | wdata[7:0] as bytes 1|2.
    - WRITE32: D1 = wdata[31:24] | wdata[23:16] as bytes 1|2.
    - Reads and INVALIDATE_LINE: D1='z.
  - CMD2, 1 cycle:
    - C1=cmd held; A1 = addr[CACHE_OFFSET_SIZE-1:0].
    - WRITE32: D1 = wdata[15:8] | wdata[7:0] as bytes 3|4.
    - WRITE8/16: D1 holds its CMD1 value.
  - WAIT_RESP:
    - A1/D1/C1 released to 'z on entry; counter increments every edge.
    - At an edge where C1==C1_RESPONSE:
      - READ8: rdata = {24'b0, D1[7:0]}.
      - READ16: rdata = {16'b0, D1[7:0], D1[15:8]}.
      - READ32: rdata[31:16] = {D1[7:0], D1[15:8]}, then go to READ2.
      - All other commands: go to DONE.
    - Counter reaching TIMEOUT_CYCLES: DONE with err=1 and rdata=0.
  - READ2: next edge, rdata[15:0] = {D1[7:0], D1[15:8]} -> DONE.
  - DONE: resp_valid(grant)=1 for one cycle, resp_err as set -> IDLE.
- Latency: handshake at edge E0; earliest response at E3. READ32 completes at E4; resp_valid is high in the cycle after the final capture.
- Back-to-back: a new handshake is possible in the cycle following DONE. No pipelining; one outstanding transaction at a time.
- The block never drives the bus outside CMD1/CMD2. C1_RESPONSE seen during CMD1/CMD2 is ignored.

Decomposition:
- Shared package: C1_* command constants, bus/cache size parameters, and the state typedef (IDLE, CMD1, CMD2, WAIT_RESP, READ2, DONE), all alongside the existing parameters/commands includes.
- Sub-module rr_arbiter2: two requests in; grant and last_grant register out.

Test Plan:
- Single READ32 from r0, addr 0x1234, cache model returns bytes 0x11,0x22 then 0x33,0x44 -> A1 shows 0x1234>>CACHE_OFFSET_SIZE in CMD1 and 0x4 in CMD2; r0_rdata=0x11223344; r0_resp_valid pulses once, err=0.
- WRITE32 from r1, data 0xC87C2505 -> D1 shows 0x7CC8 in CMD1 and 0x0525 in CMD2; bus is 'z from WAIT_RESP onwards; r1_resp_valid pulses after C1_RESPONSE.
- r0 and r1 valid together from reset, both READ16 -> r0 served first, then r1. Hold both valid for 4 transactions -> grants alternate r0, r1, r0, r1.
- READ8 with the cache silent and TIMEOUT_CYCLES=10 -> resp_valid with err=1 and rdata=0 after 10 WAIT_RESP cycles; bus 'z; next request proceeds normally.
- RESET asserted in READ2 of a READ32 -> next edge: state IDLE, bus 'z, no resp_valid; a following READ8 completes with correct data.
- C1_NOP from r0 -> C1 stays 'z throughout; r0_resp_valid one cycle after the handshake, rdata=0.
